lif_neuron_array: RTL and testbench
===================================

Name: lif_neuron_array

Overview:
- Sequential, parametrised successor to the single combinational neuron.
- Holds NUM_NEURONS membrane potentials in internal registers and accepts weighted input events over a valid/ready handshake.
- On a timestep command, sweeps all neurons one per cycle: leak, threshold compare, spike emission, membrane reset.
- Sits between the spike/weight router and the output spike collector in the SNN accelerator.

Parameters:
- NUM_NEURONS, 5, number of neurons stored.
- DATA_W, 8, membrane/weight/threshold width, signed two's complement; beta is unsigned Q0.DATA_W.
- IDX_W, 3, neuron index width; must satisfy 2^IDX_W >= NUM_NEURONS.
- REFRAC_STEPS, 2, refractory timesteps after a spike (used only with NEURON_REFRACTORY_EN).

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input event valid
- in_ready  out  1  input event ready
- in_idx  in  IDX_W  target neuron index
- in_weight  in  DATA_W  signed weight to integrate
- step_i  in  1  start timestep sweep (level sampled)
- beta  in  DATA_W  unsigned leak factor, v*beta/2^DATA_W
- v_th  in  DATA_W  signed firing threshold
- reset_mode  in  1  0 = reset to zero on spike, 1 = subtract v_th
- busy_o  out  1  sweep in progress
- spike_valid  out  1  registered spike pulse
- spike_idx  out  IDX_W  index of spiking neuron
- done_o  out  1  one-cycle pulse, sweep finished

Behaviour:
- Clocking and reset: one clock, `clock`; reset is synchronous and active-high (`reset`). Reset clears all membranes to 0 and state to IDLE; busy_o, spike_valid, done_o, spike_idx = 0. Reset mid-sweep aborts the sweep; no done_o is produced.
- States: IDLE, SWEEP.
- in_ready = (state == IDLE), combinational.
- Integrate: an event is accepted when in_valid && in_ready. Next edge: v[in_idx] = sat(v[in_idx] + in_weight). Saturation range is [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - in_idx >= NUM_NEURONS: the event is accepted and discarded, with no state change.
- Step acceptance: step_i high in IDLE at cycle T. Latches beta, v_th and reset_mode, goes to SWEEP, and sets counter i = 0.
  - An event accepted in the same cycle T is integrated before the sweep.
  - step_i while in SWEEP is ignored.
- SWEEP: neuron i is processed in cycle T+1+i.
  - leaked = (v[i] * beta) >>> DATA_W. Full-width signed product, arithmetic shift, truncation toward -inf.
  - If leaked >= v_th (signed compare): spike fires. Membrane becomes 0 when reset_mode = 0, or sat(leaked - v_th) when reset_mode = 1.
  - Otherwise v[i] = leaked.
- Spike output: spike_valid/spike_idx are registered and asserted in cycle T+2+i for one cycle. There is no backpressure.
- Timing: busy_o is high in cycles T+1 .. T+NUM_NEURONS. done_o pulses in cycle T+NUM_NEURONS+1, coincident with a possible last spike, and the block returns to IDLE in that cycle. in_ready is 0 throughout SWEEP.
- Parameters other than those listed are not runtime-configurable. beta and v_th changes during SWEEP have no effect.

Optional Feature:
- Macro: NEURON_REFRACTORY_EN.
- Defined:
  - Each neuron has a refractory counter of width clog2(REFRAC_STEPS+1), cleared on reset.
  - A spike loads the counter with REFRAC_STEPS.
  - During a sweep, a neuron with counter > 0 has its leak applied, cannot fire, and its counter decrements by 1.
  - Input events to a neuron with counter > 0 are accepted and discarded.
- Undefined: no counters exist, REFRAC_STEPS is unused, and behaviour is exactly as above.

Test Plan:
- Reset, then step with v_th=10, beta=255, NUM_NEURONS=5: no spike_valid; busy_o high T+1..T+5; done_o at T+6; all v = 0.
- Three events idx2 weight +60: v2 saturates to 127. Step with beta=255, v_th=100, reset_mode=0: leaked 126, spike_valid with spike_idx=2 at T+4, v2 = 0 afterwards.
- Event idx1 +50, step with beta=128, v_th=20, reset_mode=1: leaked 25, spike idx1 at T+3, v1 = 5. Second step: leaked 2, no spike.
- Event idx0 -100, step beta=128, v_th=10: v0 = -50, no spike. Then event idx0 -100: v0 saturates to -128. Event idx6 +50: no state change.
- step_i and in_valid (idx3, +40) in the same IDLE cycle: event applied first, with v_th=30 and beta=255 spike idx3 at T+5 (leaked 39). step_i pulsed during busy: ignored, exactly one done_o.
- With NEURON_REFRACTORY_EN and REFRAC_STEPS=2:
  - idx4 spikes; events to idx4 on the next two timesteps are discarded and no spike occurs.
  - On the third timestep, event +100 with v_th=50 and beta=255 (leaked 99) spikes again.

Source files
------------

// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons: event integration while idle, one-neuron-per-cycle timestep sweep.
// Optional per-neuron refractory counters are enabled by defining NEURON_REFRACTORY_EN.
module lif_neuron_array #(
    parameter int NUM_NEURONS  = 5,
    parameter int DATA_W       = 8,
    parameter int IDX_W        = 3,
    parameter int REFRAC_STEPS = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IDX_W-1:0]         in_idx,
    input  logic signed [DATA_W-1:0] in_weight,
    input  logic                     step_i,
    input  logic [DATA_W-1:0]        beta,
    input  logic signed [DATA_W-1:0] v_th,
    input  logic                     reset_mode,
    output logic                     busy_o,
    output logic                     spike_valid,
    output logic [IDX_W-1:0]         spike_idx,
    output logic                     done_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    localparam int PW = 2 * DATA_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
    localparam logic [IDX_W:0]   NUM_N    = (IDX_W + 1)'(NUM_NEURONS);
    localparam logic signed [DATA_W+1:0] SAT_MAX = (DATA_W + 2)'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [DATA_W+1:0] SAT_MIN = (DATA_W + 2)'(-(2 ** (DATA_W - 1)));

    function automatic logic signed [DATA_W-1:0] f_sat(input logic signed [DATA_W+1:0] x);
        if (x > SAT_MAX)
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (x < SAT_MIN)
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return x[DATA_W-1:0];
    endfunction

    logic [0:0]               r_state;
    logic [IDX_W-1:0]         r_cnt;
    logic signed [DATA_W-1:0] r_mem [NUM_NEURONS];
    logic [DATA_W-1:0]        r_beta;
    logic signed [DATA_W-1:0] r_vth;
    logic                     r_mode;

    logic signed [DATA_W-1:0] w_v;
    logic signed [PW-1:0]     w_v_ext;
    logic signed [PW-1:0]     w_b_ext;
    logic signed [PW-1:0]     w_prod;
    logic signed [DATA_W:0]   w_leak;
    logic signed [DATA_W+1:0] w_sub;
    logic signed [DATA_W+1:0] w_sum;
    logic                     w_idx_ok;
    logic                     w_in_blk;
    logic                     w_cur_ref;
    logic                     w_fire;

    assign in_ready = (r_state == ST_IDLE);
    assign busy_o   = (r_state == ST_SWEEP);

    // Leak: full-width signed product, keeping the upper bits is an arithmetic shift (floor).
    assign w_v     = r_mem[r_cnt];
    assign w_v_ext = PW'(w_v);
    assign w_b_ext = PW'($signed({1'b0, r_beta}));
    assign w_prod  = w_v_ext * w_b_ext;
    assign w_leak  = w_prod[PW-1:DATA_W];
    assign w_sub   = (DATA_W + 2)'(w_leak) - (DATA_W + 2)'(r_vth);
    assign w_fire  = (w_leak >= (DATA_W + 1)'(r_vth)) && !w_cur_ref;

    assign w_sum    = (DATA_W + 2)'(r_mem[in_idx]) + (DATA_W + 2)'(in_weight);
    assign w_idx_ok = ({1'b0, in_idx} < NUM_N);

`ifdef NEURON_REFRACTORY_EN
    localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
    logic [RW-1:0] r_ref [NUM_NEURONS];

    assign w_in_blk  = (r_ref[in_idx] != '0);
    assign w_cur_ref = (r_ref[r_cnt] != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < NUM_NEURONS; n++) r_ref[n] <= '0;
        end else if (r_state == ST_SWEEP) begin
            if (w_cur_ref)
                r_ref[r_cnt] <= r_ref[r_cnt] - RW'(1);
            else if (w_fire)
                r_ref[r_cnt] <= RW'(REFRAC_STEPS);
        end
    end
`else
    assign w_in_blk  = 1'b0;
    assign w_cur_ref = 1'b0;
`endif

    // Sweep parameters are captured once so mid-sweep input changes cannot disturb it.
    always_ff @(posedge clock) begin
        if (r_state == ST_IDLE && step_i) begin
            r_beta <= beta;
            r_vth  <= v_th;
            r_mode <= reset_mode;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            done_o      <= 1'b0;
            for (int n = 0; n < NUM_NEURONS; n++) r_mem[n] <= '0;
        end else begin
            spike_valid <= 1'b0;
            done_o      <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (in_valid && w_idx_ok && !w_in_blk)
                    r_mem[in_idx] <= f_sat(w_sum);
                if (step_i) begin
                    r_state <= ST_SWEEP;
                    r_cnt   <= '0;
                end
            end else begin
                if (w_fire) begin
                    r_mem[r_cnt] <= r_mode ? f_sat(w_sub) : '0;
                    spike_valid  <= 1'b1;
                    spike_idx    <= r_cnt;
                end else begin
                    r_mem[r_cnt] <= f_sat((DATA_W + 2)'(w_leak));
                end
                if (r_cnt == LAST_IDX) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    done_o  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Randomised bench for lif_neuron_array against an integer reference model of the neuron rules.
module tb_lif_neuron_array;

    localparam int N   = 5;
    localparam int DW  = 8;
    localparam int IW  = 3;
    localparam int RS  = 2;
`ifdef NEURON_REFRACTORY_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [IW-1:0]        in_idx = '0;
    logic signed [DW-1:0] in_weight = '0;
    logic                 step_i = 1'b0;
    logic [DW-1:0]        beta = '0;
    logic signed [DW-1:0] v_th = '0;
    logic                 reset_mode = 1'b0;
    logic                 busy_o;
    logic                 spike_valid;
    logic [IW-1:0]        spike_idx;
    logic                 done_o;

    int checks = 0;
    int failures = 0;
    int mv [N];
    int mref [N];

    lif_neuron_array #(.NUM_NEURONS(N), .DATA_W(DW), .IDX_W(IW), .REFRAC_STEPS(RS)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_weight(in_weight), .step_i(step_i), .beta(beta),
        .v_th(v_th), .reset_mode(reset_mode), .busy_o(busy_o),
        .spike_valid(spike_valid), .spike_idx(spike_idx), .done_o(done_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int x);
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    function automatic int floor256(input int p);
        if (p >= 0) return p / 256;
        return -((-p + 255) / 256);
    endfunction

    task automatic model_clear();
        for (int n = 0; n < N; n++) begin
            mv[n] = 0;
            mref[n] = 0;
        end
    endtask

    task automatic model_event(input int idx, input int w);
        if (idx < N && !(REF_EN && mref[idx] > 0))
            mv[idx] = sat(mv[idx] + w);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_event(input int idx, input int w);
        chk("evt_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_idx = IW'(idx);
        in_weight = DW'(w);
        model_event(idx, w);
        tick();
        in_valid = 1'b0;
    endtask

    // Starts a timestep in the current cycle and checks every cycle up to and including done.
    task automatic run_step(input int b, input int th, input int md,
                            input bit ev, input int eidx, input int ew, input bit poke);
        bit fire [N];
        int leak;
        chk("step_ready", int'(in_ready), 1);
        step_i = 1'b1;
        beta = DW'(b);
        v_th = DW'(th);
        reset_mode = md[0];
        if (ev) begin
            in_valid = 1'b1;
            in_idx = IW'(eidx);
            in_weight = DW'(ew);
            model_event(eidx, ew);
        end
        for (int n = 0; n < N; n++) begin
            leak = floor256(mv[n] * b);
            fire[n] = 1'b0;
            if (REF_EN && mref[n] > 0) begin
                mv[n] = leak;
                mref[n]--;
            end else if (leak >= th) begin
                fire[n] = 1'b1;
                mv[n] = (md != 0) ? sat(leak - th) : 0;
                mref[n] = RS;
            end else begin
                mv[n] = leak;
            end
        end
        tick();
        for (int c = 1; c <= N + 1; c++) begin
            chk("busy", int'(busy_o), (c <= N) ? 1 : 0);
            chk("ready", int'(in_ready), (c == N + 1) ? 1 : 0);
            chk("done", int'(done_o), (c == N + 1) ? 1 : 0);
            chk("spike_valid", int'(spike_valid), (c >= 2) ? int'(fire[c-2]) : 0);
            if (c >= 2 && fire[c-2])
                chk("spike_idx", int'(spike_idx), c - 2);
            step_i = (poke && c == 2);
            beta = DW'($urandom);
            v_th = DW'($urandom);
            reset_mode = $urandom_range(0, 1) != 0;
            in_valid = (c <= N) ? ($urandom_range(0, 1) != 0) : 1'b0;
            in_idx = IW'($urandom_range(0, N - 1));
            in_weight = DW'($urandom);
            if (c <= N) tick();
        end
    endtask

    initial begin
        int ne, idx, w;
        model_clear();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_spike", int'(spike_valid), 0);
        chk("rst_idx", int'(spike_idx), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_ready", int'(in_ready), 1);
        reset = 1'b0;
        tick();

        run_step(255, 10, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) send_event(2, 60);
        run_step(255, 100, 0, 0, 0, 0, 0);
        send_event(1, 50);
        run_step(128, 20, 1, 0, 0, 0, 0);
        run_step(128, 20, 1, 0, 0, 0, 0);
        send_event(0, -100);
        run_step(128, 10, 0, 0, 0, 0, 0);
        send_event(0, -100);
        send_event(6, 50);
        run_step(255, -127, 0, 0, 0, 0, 0);
        run_step(255, 30, 0, 1, 3, 40, 1);

        send_event(4, 100);
        run_step(255, 50, 0, 0, 0, 0, 0);
        send_event(4, 100);
        run_step(255, 50, 0, 0, 0, 0, 0);
        send_event(4, 100);
        run_step(255, 50, 0, 0, 0, 0, 0);
        send_event(4, 100);
        run_step(255, 50, 0, 0, 0, 0, 0);

        // Abort a sweep with reset: no done and all membranes back to zero.
        send_event(4, 127);
        step_i = 1'b1;
        beta = 8'd255;
        v_th = 8'sd1;
        tick();
        step_i = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        for (int c = 0; c < N + 2; c++) begin
            chk("abort_done", int'(done_o), 0);
            chk("abort_busy", int'(busy_o), 0);
            tick();
        end
        run_step(255, 0, 0, 0, 0, 0, 0);

        for (int it = 0; it < 40; it++) begin
            ne = $urandom_range(0, 4);
            for (int e = 0; e < ne; e++) begin
                idx = $urandom_range(0, 7);
                w = int'($urandom_range(0, 255)) - 128;
                send_event(idx, w);
            end
            w = int'($urandom_range(0, 255)) - 128;
            run_step($urandom_range(0, 255), int'($urandom_range(0, 160)) - 80,
                     $urandom_range(0, 1), $urandom_range(0, 1) != 0,
                     $urandom_range(0, 7), w, $urandom_range(0, 1) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
